// File: rtl/rgb2ycbcr_dct_link_pkg.sv
// Shared Q16.16 constants, colour coefficients, the 8x8 DCT cosine matrix
// and the DCT engine state encoding.
package rgb2ycbcr_dct_link_pkg;

  localparam int                 FRAC_BITS   = 16;
  localparam logic signed [63:0] ROUND       = 64'sh8000;
  localparam logic signed [31:0] LEVEL_SHIFT = 32'sh0080_0000;
  localparam int                 PIXELS      = 64;

  // Colour matrix in Q16.16; chroma carries a +128.0 offset
  localparam int Y_R  =  19595, Y_G  =  38470, Y_B  =   7471;
  localparam int CB_R = -11059, CB_G = -21709, CB_B =  32768;
  localparam int CR_R =  32768, CR_G = -27439, CR_B =  -5329;
  localparam int C_OFFSET = 128 << FRAC_BITS;

  // C[u][x] = c(u)/2 * cos((2x+1)u*pi/16), row-major u*8+x, rounded to Q16.16
  localparam int DCT_C [PIXELS] = '{
     23170,  23170,  23170,  23170,  23170,  23170,  23170,  23170,
     32138,  27246,  18205,   6393,  -6393, -18205, -27246, -32138,
     30274,  12540, -12540, -30274, -30274, -12540,  12540,  30274,
     27246,  -6393, -32138, -18205,  18205,  32138,   6393, -27246,
     23170, -23170, -23170,  23170,  23170, -23170, -23170,  23170,
     18205, -32138,   6393,  27246, -27246,  -6393,  32138, -18205,
     12540, -30274,  30274, -12540, -12540,  30274, -30274,  12540,
      6393, -18205,  27246, -32138,  32138, -27246,  18205,  -6393
  };

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_ROW, ST_COL, ST_FIN
  } dct_state_e;

  typedef struct packed {
    logic signed [31:0] y;
    logic signed [31:0] cb;
    logic signed [31:0] cr;
  } ycc_t;

  // Exact integer RGB -> YCbCr in Q16.16, no rounding
  function automatic ycc_t rgb2ycc(input logic [7:0] r, input logic [7:0] g,
                                   input logic [7:0] b);
    int   ri, gi, bi;
    ycc_t o;
    ri   = int'(r);
    gi   = int'(g);
    bi   = int'(b);
    o.y  = Y_R * ri + Y_G * gi + Y_B * bi;
    o.cb = CB_R * ri + CB_G * gi + CB_B * bi + C_OFFSET;
    o.cr = CR_R * ri + CR_G * gi + CR_B * bi + C_OFFSET;
    return o;
  endfunction

endpackage

// File: rtl/rgb2ycbcr_dct_link_dct2d_8x8.sv
// Serial two-pass 8x8 DCT: row pass T = X*C^T then column pass F = C*T,
// one element per cycle through an 8-term dot product. start restarts it.
module dct2d_8x8
  import rgb2ycbcr_dct_link_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [PIXELS-1:0][31:0] x_in,
  output logic [PIXELS-1:0][31:0] dct,
  output logic                    valid
);

  dct_state_e              state, state_nx;
  logic [5:0]              cnt;
  logic [PIXELS-1:0][31:0] xs, tp, fb;
  logic signed [63:0]      prod [8];
  logic signed [63:0]      acc;
  logic [31:0]             dot;
  logic                    row;

  assign row = (state == ST_ROW);

  // Row pass: cnt = r*8+u, dot(X[r][*], C[u][*]).
  // Column pass: cnt = u*8+v, dot(C[u][*], T[*][v]).
  for (genvar k = 0; k < 8; k++) begin : g_mac
    logic [5:0]         ci;
    logic signed [31:0] coef, data;
    assign ci      = row ? {cnt[2:0], 3'(k)} : {cnt[5:3], 3'(k)};
    assign coef    = DCT_C[ci];
    assign data    = row ? xs[{cnt[5:3], 3'(k)}] : tp[{3'(k), cnt[2:0]}];
    assign prod[k] = 64'(coef) * 64'(data);
  end

  // Sum the eight products, then round-half-up back to Q16.16
  always_comb begin
    acc = '0;
    for (int k = 0; k < 8; k++) acc = acc + prod[k];
  end
  assign dot = 32'((acc + ROUND) >>> FRAC_BITS);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next state: SETUP snapshots input, 64 row + 64 column cycles, FIN publishes
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = ST_IDLE;
      ST_SETUP: state_nx = ST_ROW;
      ST_ROW:   if (cnt == 6'd63) state_nx = ST_COL;
      ST_COL:   if (cnt == 6'd63) state_nx = ST_FIN;
      ST_FIN:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
    if (start) state_nx = ST_SETUP;
  end

  // Datapath: element counter, intermediate buffers, published result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      xs    <= '0;
      tp    <= '0;
      fb    <= '0;
      dct   <= '0;
      valid <= 1'b0;
    end else begin
      if (start || state == ST_SETUP)          cnt <= '0;
      else if (state == ST_ROW || state == ST_COL) cnt <= cnt + 6'd1;
      if (state == ST_SETUP) xs      <= x_in;
      if (state == ST_ROW)   tp[cnt] <= dot;
      if (state == ST_COL)   fb[cnt] <= dot;
      if (start) begin
        valid <= 1'b0;
      end else if (state == ST_FIN) begin
        dct   <= fb;
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb2ycbcr_dct_link.sv
// RGB block -> Q16.16 YCbCr raw planes plus a 2-D DCT per plane.
// A new block is any change on the RGB buses (or the first edge after reset).
module rgb2ycbcr_dct_link
  import rgb2ycbcr_dct_link_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INPUT_WIDTH = 8,
  parameter int DATA_DEPTH  = 8
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic [INPUT_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] r_all,
  input  logic [INPUT_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] g_all,
  input  logic [INPUT_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0] b_all,
  output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0]  y_raw,
  output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0]  cb_raw,
  output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0]  cr_raw,
  output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0]  y_dct,
  output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0]  cb_dct,
  output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0]  cr_dct,
  output logic                                       y_out_valid,
  output logic                                       cb_out_valid,
  output logic                                       cr_out_valid
);

  localparam int PIXEL_COUNT = DATA_DEPTH * DATA_DEPTH;
  localparam int IN_BITS     = INPUT_WIDTH * PIXEL_COUNT;

  logic [IN_BITS-1:0]                      r_cap, g_cap, b_cap;
  logic                                    primed, chg;
  logic [PIXEL_COUNT-1:0][DATA_WIDTH-1:0]  y_nx, cb_nx, cr_nx;
  logic [PIXEL_COUNT-1:0][DATA_WIDTH-1:0]  y_r, cb_r, cr_r;
  logic [PIXEL_COUNT-1:0][DATA_WIDTH-1:0]  y_ls, cb_ls, cr_ls;
  logic [PIXEL_COUNT-1:0][DATA_WIDTH-1:0]  y_d, cb_d, cr_d;

  assign chg = !primed || (r_all != r_cap) || (g_all != g_cap) || (b_all != b_cap);

  // Per-pixel colour conversion and the -128.0 level shift feeding the DCTs
  for (genvar i = 0; i < PIXEL_COUNT; i++) begin : g_pix
    ycc_t c;
    assign c = rgb2ycc(r_all[i*INPUT_WIDTH +: INPUT_WIDTH],
                       g_all[i*INPUT_WIDTH +: INPUT_WIDTH],
                       b_all[i*INPUT_WIDTH +: INPUT_WIDTH]);
    assign y_nx[i]  = c.y;
    assign cb_nx[i] = c.cb;
    assign cr_nx[i] = c.cr;
    assign y_ls[i]  = y_r[i]  - LEVEL_SHIFT;
    assign cb_ls[i] = cb_r[i] - LEVEL_SHIFT;
    assign cr_ls[i] = cr_r[i] - LEVEL_SHIFT;
  end

  // Capture a changed block and its converted planes on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      primed <= 1'b0;
      r_cap  <= '0;
      g_cap  <= '0;
      b_cap  <= '0;
      y_r    <= '0;
      cb_r   <= '0;
      cr_r   <= '0;
    end else if (chg) begin
      primed <= 1'b1;
      r_cap  <= r_all;
      g_cap  <= g_all;
      b_cap  <= b_all;
      y_r    <= y_nx;
      cb_r   <= cb_nx;
      cr_r   <= cr_nx;
    end
  end

  dct2d_8x8 u_dct_y  (.clk(clk), .reset_n(reset_n), .start(chg), .x_in(y_ls),
                      .dct(y_d),  .valid(y_out_valid));
  dct2d_8x8 u_dct_cb (.clk(clk), .reset_n(reset_n), .start(chg), .x_in(cb_ls),
                      .dct(cb_d), .valid(cb_out_valid));
  dct2d_8x8 u_dct_cr (.clk(clk), .reset_n(reset_n), .start(chg), .x_in(cr_ls),
                      .dct(cr_d), .valid(cr_out_valid));

  assign y_raw  = y_r;
  assign cb_raw = cb_r;
  assign cr_raw = cr_r;
  assign y_dct  = y_d;
  assign cb_dct = cb_d;
  assign cr_dct = cr_d;

endmodule

// File: tb/tb_rgb2ycbcr_dct_link.sv
// Directed + random bench: exact integer colour model, floating-point DCT model.
module tb_rgb2ycbcr_dct_link;

  localparam int N = 64;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N*8-1:0] r_all = '0, g_all = '0, b_all = '0;
  logic [N*32-1:0] y_raw, cb_raw, cr_raw, y_dct, cb_dct, cr_dct;
  logic           y_out_valid, cb_out_valid, cr_out_valid;

  int  n_chk = 0, n_pass = 0;
  int  rr [N], gg [N], bb [N];
  real cm [8][8];
  real exp_last [3][N];
  bit  have_last = 0;

  always #5 clk = ~clk;

  rgb2ycbcr_dct_link dut (
    .clk(clk), .reset_n(reset_n),
    .r_all(r_all), .g_all(g_all), .b_all(b_all),
    .y_raw(y_raw), .cb_raw(cb_raw), .cr_raw(cr_raw),
    .y_dct(y_dct), .cb_dct(cb_dct), .cr_dct(cr_dct),
    .y_out_valid(y_out_valid), .cb_out_valid(cb_out_valid),
    .cr_out_valid(cr_out_valid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] got, input logic [31:0] exp);
    longint d;
    d = longint'($signed(got)) - longint'($signed(exp));
    if (d < 0) d = -d;
    n_chk++;
    assert ((d <= 32768) === 1'b1) n_pass++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic chk_valid(input string tag, input logic exp);
    chk(tag, {61'd0, y_out_valid, cb_out_valid, cr_out_valid}, {61'd0, {3{exp}}});
  endtask

  function automatic int exp_raw(int p, int i);
    case (p)
      0:       return 19595*rr[i] + 38470*gg[i] + 7471*bb[i];
      1:       return -11059*rr[i] - 21709*gg[i] + 32768*bb[i] + (128 << 16);
      default: return 32768*rr[i] - 27439*gg[i] - 5329*bb[i] + (128 << 16);
    endcase
  endfunction

  function automatic logic [31:0] bus_of(int sel, int i);
    case (sel)
      0:       return y_raw[i*32 +: 32];
      1:       return cb_raw[i*32 +: 32];
      2:       return cr_raw[i*32 +: 32];
      3:       return y_dct[i*32 +: 32];
      4:       return cb_dct[i*32 +: 32];
      default: return cr_dct[i*32 +: 32];
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      r_all[i*8 +: 8] = 8'(rr[i]);
      g_all[i*8 +: 8] = 8'(gg[i]);
      b_all[i*8 +: 8] = 8'(bb[i]);
    end
  endtask

  task automatic fill_const(input int r, input int g, input int b);
    for (int i = 0; i < N; i++) begin rr[i] = r; gg[i] = g; bb[i] = b; end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      rr[i] = int'($urandom_range(0, 255));
      gg[i] = int'($urandom_range(0, 255));
      bb[i] = int'($urandom_range(0, 255));
    end
  endtask

  task automatic check_raw(input string tag);
    for (int p = 0; p < 3; p++) begin
      int bad = 0, wi = 0;
      for (int i = 0; i < N; i++)
        if (bus_of(p, i) !== 32'(exp_raw(p, i))) begin bad++; wi = i; end
      chk($sformatf("%s raw%0d[%0d] (dut %h model %h) bad-count", tag, p, wi,
                    bus_of(p, wi), 32'(exp_raw(p, wi))), 64'(bad), 64'd0);
    end
  endtask

  // F[u][v] = sum_r sum_c C[u][r] * X[r][c] * C[v][c], X level-shifted
  task automatic check_dct(input string tag);
    real x [N];
    for (int p = 0; p < 3; p++) begin
      int  bad = 0, wi = 0;
      for (int i = 0; i < N; i++) x[i] = real'(exp_raw(p, i)) / 65536.0 - 128.0;
      for (int u = 0; u < 8; u++)
        for (int v = 0; v < 8; v++) begin
          real f = 0.0, d;
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) f += cm[u][r] * cm[v][c] * x[r*8+c];
          exp_last[p][u*8+v] = f * 65536.0;
          d = real'($signed(bus_of(3+p, u*8+v))) - f * 65536.0;
          if (d < 0.0) d = -d;
          if (d > 32768.0) begin bad++; wi = u*8+v; end
        end
      chk($sformatf("%s dct%0d[%0d] (dut %h model %0.1f) bad-count", tag, p, wi,
                    bus_of(3+p, wi), exp_last[p][wi]), 64'(bad), 64'd0);
    end
    have_last = 1;
  endtask

  // Previous block's coefficients must stay on the outputs while recomputing
  task automatic check_hold(input string tag);
    int bad = 0;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N; i++) begin
        real d = real'($signed(bus_of(3+p, i))) - exp_last[p][i];
        if (d < 0.0) d = -d;
        if (d > 32768.0) bad++;
      end
    chk($sformatf("%s dct hold bad-count", tag), 64'(bad), 64'd0);
  endtask

  // Capture edge, no valid through edge 129, valid and results at edge 130
  task automatic run_block(input string tag, input bit do_drive);
    logic any_v = 1'b0;
    bit   hold  = have_last;
    if (do_drive) drive();
    @(posedge clk); #1;
    check_raw(tag);
    chk_valid($sformatf("%s valid at capture", tag), 1'b0);
    if (hold) check_hold(tag);
    for (int c = 1; c < 130; c++) begin
      @(posedge clk); #1;
      any_v |= y_out_valid | cb_out_valid | cr_out_valid;
    end
    chk($sformatf("%s early valid", tag), {63'd0, any_v}, 64'd0);
    @(posedge clk); #1;
    chk_valid($sformatf("%s valid at 130", tag), 1'b1);
    check_dct(tag);
  endtask

  initial begin
    logic any_v;
    for (int u = 0; u < 8; u++)
      for (int k = 0; k < 8; k++)
        cm[u][k] = ((u == 0) ? 1.0 / $sqrt(2.0) : 1.0) / 2.0 *
                   $cos(real'((2*k+1)*u) * 3.14159265358979323846 / 16.0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs nonzero", {58'd0, |y_raw, |cb_raw, |cr_raw, |y_dct, |cb_dct, |cr_dct}, 64'd0);
    chk_valid("reset valid", 1'b0);
    reset_n = 1'b1;

    fill_const(0, 0, 0);
    run_block("black", 1);
    chk("black y_raw0", 64'(y_raw[31:0]), 64'h0);
    chk("black cb_raw0", 64'(cb_raw[31:0]), 64'h0080_0000);
    chk("black cr_raw0", 64'(cr_raw[31:0]), 64'h0080_0000);
    chk_tol("black y_dc", y_dct[31:0], 32'hFC00_0000);
    repeat (5) @(posedge clk);
    #1;
    chk_valid("black valid held", 1'b1);
    check_dct("black held");

    fill_const(255, 255, 255);
    run_block("white", 1);
    chk("white y_raw0", 64'(y_raw[31:0]), 64'h00FF_0000);
    chk("white cb_raw63", 64'(cb_raw[63*32 +: 32]), 64'h0080_0000);
    chk_tol("white y_dc", y_dct[31:0], 32'h03F8_0000);

    fill_const(255, 0, 0);
    run_block("red", 1);
    chk("red y_raw", 64'(y_raw[5*32 +: 32]), 64'h004C_3E75);
    chk("red cb_raw", 64'(cb_raw[5*32 +: 32]), 64'h0054_F833);
    chk("red cr_raw", 64'(cr_raw[5*32 +: 32]), 64'h00FF_8000);

    for (int b = 0; b < 100; b++) begin
      fill_random();
      run_block($sformatf("rand%0d", b), 1);
    end

    // Abort: change the block 60 edges into a computation
    fill_random();
    drive();
    any_v = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      any_v |= y_out_valid | cb_out_valid | cr_out_valid;
    end
    chk("abort first-block valid", {63'd0, any_v}, 64'd0);
    fill_random();
    run_block("abort second", 1);

    // Reset mid-computation, then recapture of the held input
    fill_random();
    drive();
    @(posedge clk); #1;
    repeat (40) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset outputs nonzero", {58'd0, |y_raw, |cb_raw, |cr_raw, |y_dct, |cb_dct, |cr_dct}, 64'd0);
    chk_valid("midreset valid", 1'b0);
    have_last = 0;
    #1;
    reset_n = 1'b1;
    run_block("after reset", 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
